// File: rtl/irq_ack_sequencer_pkg.sv
// Shared PIC definitions: sizes, sequencer states, spurious level and the
// lowest-index-wins priority encoder used by the resolver and EOI logic.
package pic_pkg;

    localparam int NUM_IRQ = 8;
    localparam int LVL_W   = 3;

    localparam logic [LVL_W-1:0] SPURIOUS_LVL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK1 = 2'd2,
        ST_ACK2 = 2'd3
    } seq_state_e;

    // Returns {found, index} of the lowest-index set bit (IR0 is highest priority).
    function automatic logic [LVL_W:0] prio_enc(input logic [NUM_IRQ-1:0] vec);
        logic [LVL_W:0] res;
        res = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (vec[i]) begin
                res = {1'b1, LVL_W'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_ack_sequencer_if.sv
// CPU-side handshake of the sequencer: INT out, INTA pulses in, vector byte out.
interface irq_ack_if;

    logic                        interruptAck;
    logic                        intOut;
    logic [pic_pkg::NUM_IRQ-1:0] dataOut;
    logic                        dataValid;

    modport master (
        output interruptAck,
        input  intOut,
        input  dataOut,
        input  dataValid
    );

    modport slave (
        input  interruptAck,
        output intOut,
        output dataOut,
        output dataValid
    );

endinterface

// File: rtl/irq_ack_sequencer_resolver.sv
// Fixed-priority resolver, fully nested mode: the lowest pending index wins and
// is eligible only when it outranks every level currently in service.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IRQ-1:0] pending_i,
    input  logic [NUM_IRQ-1:0] in_service_i,
    output logic               eligible_o,
    output logic [LVL_W-1:0]   winner_o
);

    logic [LVL_W:0] pend_enc;
    logic [LVL_W:0] isr_enc;

    // Compare the best pending level against the best in-service level.
    always_comb begin
        pend_enc   = prio_enc(pending_i);
        isr_enc    = prio_enc(in_service_i);
        winner_o   = pend_enc[LVL_W-1:0];
        eligible_o = pend_enc[LVL_W] &&
                     (!isr_enc[LVL_W] || (pend_enc[LVL_W-1:0] < isr_enc[LVL_W-1:0]));
    end

endmodule

// File: rtl/irq_ack_sequencer.sv
// 8259A interrupt acknowledge sequencer: raises INT for the eligible request,
// runs the two-pulse 8086 INTA cycle and maintains the ISR under EOI commands.
// Optional macro IRQ_ACK_AUTO_EOI_EN adds the autoEoi input (ICW4 AEOI).
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no request outstanding toward the CPU
// ST_REQ  | INT asserted, waiting for the first INTA pulse
// ST_ACK1 | level latched and ISR set, waiting for the second INTA pulse
// ST_ACK2 | vector byte presented for one cycle
module irq_ack_sequencer
    import pic_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] interruptRequest,
    input  logic [NUM_IRQ-1:0] interruptMask,
    input  logic [4:0]         vectorBase,
    input  logic               eoiPulse,
    input  logic               eoiSpecific,
    input  logic [LVL_W-1:0]   eoiLevel,
`ifdef IRQ_ACK_AUTO_EOI_EN
    input  logic               autoEoi,
`endif
    output logic [NUM_IRQ-1:0] irrClear,
    output logic [NUM_IRQ-1:0] inService,
    irq_ack_if.slave           cpu
);

    seq_state_e          state_q, state_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [NUM_IRQ-1:0]  isr_q, isr_d;
    logic [NUM_IRQ-1:0]  irr_clr_q, irr_clr_d;
    logic                int_q, int_d;
    logic [NUM_IRQ-1:0]  data_q, data_d;
    logic                valid_q, valid_d;

    logic [NUM_IRQ-1:0]  pending;
    logic                eligible;
    logic [LVL_W-1:0]    winner;
    logic                enter_ack1;
    logic [LVL_W:0]      eoi_enc;

    assign pending = interruptRequest & ~interruptMask;

    priority_resolver u_resolver (
        .pending_i    (pending),
        .in_service_i (isr_q),
        .eligible_o   (eligible),
        .winner_o     (winner)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            level_q   <= '0;
            isr_q     <= '0;
            irr_clr_q <= '0;
            int_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            isr_q     <= isr_d;
            irr_clr_q <= irr_clr_d;
            int_q     <= int_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    // Next state, level latch and the registered-output next values.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        enter_ack1 = 1'b0;
        case (state_q)
            ST_IDLE: if (eligible) state_d = ST_REQ;
            ST_REQ: begin
                // The pulse edge wins over a disappearing request: that is the spurious path.
                if (cpu.interruptAck) begin
                    state_d    = ST_ACK1;
                    enter_ack1 = 1'b1;
                end else if (!eligible) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK1: if (cpu.interruptAck) state_d = ST_ACK2;
            ST_ACK2: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (enter_ack1) begin
            level_d = eligible ? winner : SPURIOUS_LVL;
        end

        int_d     = (state_d == ST_REQ);
        valid_d   = (state_d == ST_ACK2);
        irr_clr_d = (enter_ack1 && eligible) ? (NUM_IRQ'(1) << winner) : '0;
        data_d    = (state_q == ST_ACK1 && state_d == ST_ACK2) ?
                    {vectorBase, level_q} : data_q;
    end

    // ISR update: EOI clears land first so a same-cycle ACK1 set always survives.
    always_comb begin
        isr_d   = isr_q;
        eoi_enc = prio_enc(isr_q);
        if (eoiPulse) begin
            if (eoiSpecific) begin
                isr_d[eoiLevel] = 1'b0;
            end else if (eoi_enc[LVL_W]) begin
                isr_d[eoi_enc[LVL_W-1:0]] = 1'b0;
            end
        end
`ifdef IRQ_ACK_AUTO_EOI_EN
        if (autoEoi && state_q == ST_ACK2) begin
            isr_d[level_q] = 1'b0;
        end
`endif
        if (enter_ack1 && eligible) begin
            isr_d[winner] = 1'b1;
        end
    end

    assign irrClear      = irr_clr_q;
    assign inService     = isr_q;
    assign cpu.intOut    = int_q;
    assign cpu.dataOut   = data_q;
    assign cpu.dataValid = valid_q;

endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Self-checking bench for irq_ack_sequencer: directed scenarios plus a
// randomized run against a transaction-level model of the PIC rules.
module tb_irq_ack_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic [4:0] vb;
    logic       eoi_p;
    logic       eoi_s;
    logic [2:0] eoi_l;
`ifdef IRQ_ACK_AUTO_EOI_EN
    logic       auto_eoi;
`endif
    logic [7:0] irr_clear;
    logic [7:0] in_service;

    int errors = 0;
    int checks = 0;

    irq_ack_if bus ();

    irq_ack_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .interruptRequest (req),
        .interruptMask    (mask),
        .vectorBase       (vb),
        .eoiPulse         (eoi_p),
        .eoiSpecific      (eoi_s),
        .eoiLevel         (eoi_l),
`ifdef IRQ_ACK_AUTO_EOI_EN
        .autoEoi          (auto_eoi),
`endif
        .irrClear         (irr_clear),
        .inService        (in_service),
        .cpu              (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: index of the lowest set bit, 8 when empty.
    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return 8;
    endfunction

    // Model: level that would be granted, -1 when nothing outranks the ISR.
    function automatic int model_pick(input logic [7:0] r, input logic [7:0] m, input logic [7:0] isr);
        int w;
        int s;
        w = lowest(r & ~m);
        s = lowest(isr);
        if (w < 8 && w < s) return w;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        bus.interruptAck = 1'b1;
        step();
        bus.interruptAck = 1'b0;
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl);
        eoi_p = 1'b1; eoi_s = spec; eoi_l = lvl;
        step();
        eoi_p = 1'b0; eoi_s = 1'b0; eoi_l = 3'd0;
    endtask

    task automatic serve(input logic [7:0] r);
        req = r;
        step();
        ack_pulse();
        req = 8'h00;
        ack_pulse();
        step();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req = 8'h00; mask = 8'h00; vb = 5'h08;
        eoi_p = 1'b0; eoi_s = 1'b0; eoi_l = 3'd0;
        bus.interruptAck = 1'b0;
`ifdef IRQ_ACK_AUTO_EOI_EN
        auto_eoi = 1'b0;
`endif
        #17;
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.intOut !== 1'b0) begin errors++; $display("FAIL reset_int: got %0h want 0", bus.intOut); end
        checks++; if (irr_clear !== 8'h00) begin errors++; $display("FAIL reset_irrclr: got %0h want 0", irr_clear); end
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL reset_isr: got %0h want 0", in_service); end
        checks++; if (bus.dataOut !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.dataOut); end
        checks++; if (bus.dataValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", bus.dataValid); end
    endtask

    task automatic test_basic();
        mask = 8'h00; vb = 5'h08; req = 8'h04;
        step();
        checks++; if (bus.intOut !== 1'b1) begin errors++; $display("FAIL basic_int: got %0h want 1", bus.intOut); end
        ack_pulse();
        checks++; if (irr_clear !== 8'h04) begin errors++; $display("FAIL basic_irrclr: got %0h want 04", irr_clear); end
        checks++; if (in_service !== 8'h04) begin errors++; $display("FAIL basic_isr: got %0h want 04", in_service); end
        checks++; if (bus.intOut !== 1'b0) begin errors++; $display("FAIL basic_int_low: got %0h want 0", bus.intOut); end
        req = 8'h00;
        step();
        checks++; if (irr_clear !== 8'h00) begin errors++; $display("FAIL basic_irrclr_pulse: got %0h want 0", irr_clear); end
        ack_pulse();
        checks++; if (bus.dataOut !== 8'h42) begin errors++; $display("FAIL basic_data: got %0h want 42", bus.dataOut); end
        checks++; if (bus.dataValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h want 1", bus.dataValid); end
        step();
        checks++; if (bus.dataValid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse: got %0h want 0", bus.dataValid); end
        checks++; if (bus.dataOut !== 8'h42) begin errors++; $display("FAIL basic_data_hold: got %0h want 42", bus.dataOut); end
        eoi(1'b0, 3'd0);
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL basic_eoi: got %0h want 0", in_service); end
    endtask

    task automatic test_priority();
        vb = 5'h08; req = 8'h0A; mask = 8'h02;
        step();
        ack_pulse();
        checks++; if (irr_clear !== 8'h08) begin errors++; $display("FAIL prio_mask_clr: got %0h want 08", irr_clear); end
        req = 8'h00;
        ack_pulse();
        checks++; if (bus.dataOut !== 8'h43) begin errors++; $display("FAIL prio_mask_data: got %0h want 43", bus.dataOut); end
        step();
        eoi(1'b0, 3'd0);
        mask = 8'h00; req = 8'h0A;
        step();
        ack_pulse();
        checks++; if (irr_clear !== 8'h02) begin errors++; $display("FAIL prio_nomask_clr: got %0h want 02", irr_clear); end
        req = 8'h00;
        ack_pulse();
        checks++; if (bus.dataOut !== 8'h41) begin errors++; $display("FAIL prio_nomask_data: got %0h want 41", bus.dataOut); end
        step();
        eoi(1'b0, 3'd0);
    endtask

    task automatic test_nesting();
        serve(8'h04);
        checks++; if (in_service !== 8'h04) begin errors++; $display("FAIL nest_isr0: got %0h want 04", in_service); end
        req = 8'h20;
        step();
        step();
        checks++; if (bus.intOut !== 1'b0) begin errors++; $display("FAIL nest_blocked: got %0h want 0", bus.intOut); end
        req = 8'h21;
        step();
        checks++; if (bus.intOut !== 1'b1) begin errors++; $display("FAIL nest_int: got %0h want 1", bus.intOut); end
        ack_pulse();
        checks++; if (in_service !== 8'h05) begin errors++; $display("FAIL nest_isr: got %0h want 05", in_service); end
        req = 8'h20;
        ack_pulse();
        checks++; if (bus.dataOut !== 8'h40) begin errors++; $display("FAIL nest_data: got %0h want 40", bus.dataOut); end
        step();
        eoi(1'b0, 3'd0);
        checks++; if (in_service !== 8'h04) begin errors++; $display("FAIL nest_eoi: got %0h want 04", in_service); end
        eoi(1'b0, 3'd0);
        req = 8'h00;
        step();
        step();
        checks++; if (bus.intOut !== 1'b0) begin errors++; $display("FAIL nest_idle: got %0h want 0", bus.intOut); end
    endtask

    task automatic test_withdraw();
        req = 8'h10;
        step();
        checks++; if (bus.intOut !== 1'b1) begin errors++; $display("FAIL wd_int: got %0h want 1", bus.intOut); end
        req = 8'h00;
        step();
        checks++; if (bus.intOut !== 1'b0) begin errors++; $display("FAIL wd_int_drop: got %0h want 0", bus.intOut); end
        ack_pulse();
        step();
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL wd_idle_ack_isr: got %0h want 0", in_service); end
        ack_pulse();
        step();
        checks++; if (bus.dataValid !== 1'b0) begin errors++; $display("FAIL wd_idle_ack_valid: got %0h want 0", bus.dataValid); end
    endtask

    task automatic test_spurious();
        vb = 5'h08; req = 8'h10;
        step();
        req = 8'h00;
        ack_pulse();
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL spur_isr: got %0h want 0", in_service); end
        checks++; if (irr_clear !== 8'h00) begin errors++; $display("FAIL spur_irrclr: got %0h want 0", irr_clear); end
        ack_pulse();
        checks++; if (bus.dataOut !== 8'h47) begin errors++; $display("FAIL spur_data: got %0h want 47", bus.dataOut); end
        checks++; if (bus.dataValid !== 1'b1) begin errors++; $display("FAIL spur_valid: got %0h want 1", bus.dataValid); end
        step();
    endtask

    // Levels 2 and 7 in service, level 1 acknowledged while level 7 is EOI'd in the same cycle.
    task automatic test_eoi_concurrent();
        serve(8'h80);
        serve(8'h04);
        checks++; if (in_service !== 8'h84) begin errors++; $display("FAIL ceoi_setup: got %0h want 84", in_service); end
        req = 8'h02;
        step();
        bus.interruptAck = 1'b1; eoi_p = 1'b1; eoi_s = 1'b1; eoi_l = 3'd7;
        step();
        bus.interruptAck = 1'b0; eoi_p = 1'b0; eoi_s = 1'b0; eoi_l = 3'd0;
        checks++; if (in_service !== 8'h06) begin errors++; $display("FAIL ceoi_isr: got %0h want 06", in_service); end
        req = 8'h00;
        ack_pulse();
        step();
        eoi(1'b1, 3'd1);
        eoi(1'b1, 3'd2);
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL ceoi_clear: got %0h want 0", in_service); end
        req = 8'h08;
        step();
        bus.interruptAck = 1'b1; eoi_p = 1'b1; eoi_s = 1'b1; eoi_l = 3'd3;
        step();
        bus.interruptAck = 1'b0; eoi_p = 1'b0; eoi_s = 1'b0; eoi_l = 3'd0;
        checks++; if (in_service !== 8'h08) begin errors++; $display("FAIL ceoi_samebit: got %0h want 08", in_service); end
        req = 8'h00;
        ack_pulse();
        step();
        eoi(1'b0, 3'd0);
    endtask

    task automatic test_reset_mid();
        vb = 5'h1F; req = 8'h04;
        step();
        ack_pulse();
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({bus.intOut, bus.dataValid, irr_clear, in_service, bus.dataOut} !== 26'd0) begin
            errors++;
            $display("FAIL rstmid_outs: got int=%0h valid=%0h clr=%0h isr=%0h data=%0h want all 0",
                     bus.intOut, bus.dataValid, irr_clear, in_service, bus.dataOut);
        end
        req = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ack_pulse();
        checks++; if (bus.dataValid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0h want 0", bus.dataValid); end
        step();
        checks++; if (bus.dataOut !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %0h want 0", bus.dataOut); end
    endtask

`ifdef IRQ_ACK_AUTO_EOI_EN
    task automatic test_auto_eoi();
        auto_eoi = 1'b1; vb = 5'h08; mask = 8'h00; req = 8'h04;
        step();
        ack_pulse();
        checks++; if (in_service !== 8'h04) begin errors++; $display("FAIL aeoi_set: got %0h want 04", in_service); end
        req = 8'h00;
        ack_pulse();
        checks++; if (bus.dataOut !== 8'h42) begin errors++; $display("FAIL aeoi_data: got %0h want 42", bus.dataOut); end
        step();
        checks++; if (in_service !== 8'h00) begin errors++; $display("FAIL aeoi_clear: got %0h want 0", in_service); end
        auto_eoi = 1'b0;
    endtask
`endif

    task automatic test_random();
        logic [7:0] m_isr;
        int         pick;
        int         lvl;
        logic [7:0] exp_clr;
        m_isr = 8'h00;
        apply_reset();
        for (int n = 0; n < 200; n++) begin
            req  = 8'($urandom_range(0, 255));
            mask = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
            vb   = 5'($urandom_range(0, 31));
            step();
            pick = model_pick(req, mask, m_isr);
            checks++; if (bus.intOut !== (pick >= 0)) begin errors++; $display("FAIL rnd_int[%0d]: got %0h want %0h", n, bus.intOut, pick >= 0); end
            if (pick >= 0) begin
                if ($urandom_range(0, 3) == 0) req = 8'($urandom_range(0, 255));
                pick = model_pick(req, mask, m_isr);
                ack_pulse();
                if (pick >= 0) begin
                    lvl = pick;
                    exp_clr = 8'h01 << pick;
                    m_isr[pick] = 1'b1;
                end else begin
                    lvl = 7;
                    exp_clr = 8'h00;
                end
                checks++; if (irr_clear !== exp_clr) begin errors++; $display("FAIL rnd_clr[%0d]: got %0h want %0h", n, irr_clear, exp_clr); end
                checks++; if (in_service !== m_isr) begin errors++; $display("FAIL rnd_isr[%0d]: got %0h want %0h", n, in_service, m_isr); end
                req = 8'h00;
                ack_pulse();
                checks++; if (bus.dataOut !== {vb, 3'(lvl)} || bus.dataValid !== 1'b1) begin
                    errors++; $display("FAIL rnd_vec[%0d]: got %0h/%0h want %0h/1", n, bus.dataOut, bus.dataValid, {vb, 3'(lvl)});
                end
                step();
            end else begin
                req = 8'h00;
                step();
            end
            if ($urandom_range(0, 1) == 1) begin
                logic       s;
                logic [2:0] l;
                s = 1'($urandom_range(0, 1));
                l = 3'($urandom_range(0, 7));
                if (s) m_isr[l] = 1'b0;
                else if (lowest(m_isr) < 8) m_isr[lowest(m_isr)] = 1'b0;
                eoi(s, l);
                checks++; if (in_service !== m_isr) begin errors++; $display("FAIL rnd_eoi[%0d]: got %0h want %0h", n, in_service, m_isr); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_nesting();
        test_withdraw();
        test_spurious();
        test_eoi_concurrent();
        test_reset_mid();
`ifdef IRQ_ACK_AUTO_EOI_EN
        test_auto_eoi();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
